// File: rtl/analog_btn_decoder_if.sv
// Sample bus into the analog button decoder and its debounced button outputs.
interface analog_btn_decoder_if #(
  parameter int NCH = 2,
  parameter int DW  = 16
);
  logic                  sample_valid;
  logic [NCH*DW-1:0]     sample_data;
  logic [NCH-1:0]        BTN;
  logic                  btn_event;
  logic                  sat;

  modport master (output sample_valid, sample_data, input BTN, btn_event, sat);
  modport slave  (input sample_valid, sample_data, output BTN, btn_event, sat);
endinterface

// File: rtl/analog_btn_decoder.sv
// Hysteresis + debounce decoder turning NCH analog samples into button bits,
// with all-channel saturation masking.
module analog_btn_chan #(
  parameter int DW     = 16,
  parameter int TH_ON  = 1000,
  parameter int TH_OFF = 800,
  parameter int DEB    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [DW-1:0] smp_i,
  output logic          pressed_o
);
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} st_e;

  localparam logic [DW-1:0] TON  = DW'(TH_ON);
  localparam logic [DW-1:0] TOFF = DW'(TH_OFF);
  localparam logic [7:0]    DEB8 = 8'(DEB);

  st_e        st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic       press, rel;
  logic [7:0] cnt_inc;

  // Samples inside [TH_OFF, TH_ON] qualify for neither direction.
  assign press   = smp_i > TON;
  assign rel     = smp_i < TOFF;
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (en_i) begin
      case (st_q)
        RELEASED: if (press) begin
          cnt_d = 8'd1;
          st_d  = (DEB == 1) ? PRESSED : PRESS_PEND;
        end
        PRESS_PEND: if (press) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB8) st_d = PRESSED;
        end else begin
          st_d  = RELEASED;
          cnt_d = 8'd0;
        end
        PRESSED: if (rel) begin
          cnt_d = 8'd1;
          st_d  = (DEB == 1) ? RELEASED : RELEASE_PEND;
        end
        RELEASE_PEND: if (rel) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB8) st_d = RELEASED;
        end else begin
          st_d  = PRESSED;
          cnt_d = 8'd0;
        end
        default: begin
          st_d  = RELEASED;
          cnt_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= RELEASED;
      cnt_q <= 8'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign pressed_o = (st_q == PRESSED) || (st_q == RELEASE_PEND);
endmodule

module analog_btn_decoder #(
  parameter int NCH      = 2,
  parameter int DW       = 16,
  parameter int TH_ON    = 1000,
  parameter int TH_OFF   = 800,
  parameter int TH_SAT   = 2000,
  parameter int SAT_MODE = 1,
  parameter int DEB      = 3
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  analog_btn_decoder_if.slave  bus
);
  localparam logic [DW-1:0] TSAT = DW'(TH_SAT);

  logic [NCH-1:0] over_sat, pressed;
  logic [NCH-1:0] btn_q, btn_d;
  logic           ev_q, ev_d, sat_q, sat_d;
  logic           sat_smp, en;

  // A saturated frame freezes every channel; only the sat flag moves.
  assign sat_smp = (SAT_MODE != 0) && (&over_sat);
  assign en      = bus.sample_valid && !sat_smp;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign over_sat[g] = bus.sample_data[g*DW +: DW] > TSAT;
    analog_btn_chan #(
      .DW(DW), .TH_ON(TH_ON), .TH_OFF(TH_OFF), .DEB(DEB)
    ) u_ch (
      .clk       (CLK100MHZ),
      .rst       (rst),
      .en_i      (en),
      .smp_i     (bus.sample_data[g*DW +: DW]),
      .pressed_o (pressed[g])
    );
  end

  assign sat_d = bus.sample_valid ? sat_smp : sat_q;
  assign btn_d = pressed & ~{NCH{sat_q}};
  assign ev_d  = btn_d != btn_q;

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
      ev_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      btn_q <= btn_d;
      ev_q  <= ev_d;
      sat_q <= sat_d;
    end
  end

  assign bus.BTN       = btn_q;
  assign bus.btn_event = ev_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_analog_btn_decoder.sv
// Scoreboard bench: a behavioural count-based model predicts BTN/btn_event/sat per cycle.
module tb_analog_btn_decoder;
  localparam int NCH = 2, DW = 16, DEB = 3;
  localparam int TH_ON = 1000, TH_OFF = 800, TH_SAT = 2000;

  typedef struct packed {
    logic [NCH-1:0] btn;
    logic           ev;
    logic           sat;
  } exp_t;

  logic CLK100MHZ = 1'b0;
  logic rst;
  always #5 CLK100MHZ = ~CLK100MHZ;

  analog_btn_decoder_if #(.NCH(NCH), .DW(DW)) bus ();

  analog_btn_decoder #(
    .NCH(NCH), .DW(DW), .TH_ON(TH_ON), .TH_OFF(TH_OFF),
    .TH_SAT(TH_SAT), .SAT_MODE(1), .DEB(DEB)
  ) dut (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .bus       (bus)
  );

  exp_t           sb[$];
  int             total = 0, bad = 0;
  logic [NCH-1:0] mp, mbtn;
  logic           msat;
  int             mc[NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mp = '0; mbtn = '0; msat = 1'b0;
    for (int c = 0; c < NCH; c++) mc[c] = 0;
    sb.delete();
  endtask

  // One clock: drive at negedge, predict, compare just after the rising edge.
  task automatic step(input logic v, input int d0, input int d1);
    exp_t e;
    int   s;
    @(negedge CLK100MHZ);
    bus.sample_valid = v;
    bus.sample_data  = {DW'(d1), DW'(d0)};
    e.btn = mp & ~{NCH{msat}};
    e.ev  = (e.btn != mbtn);
    mbtn  = e.btn;
    if (v) begin
      msat = (d0 > TH_SAT) && (d1 > TH_SAT);
      if (!msat) begin
        for (int c = 0; c < NCH; c++) begin
          s = (c == 0) ? d0 : d1;
          if (!mp[c]) begin
            if (s > TH_ON) mc[c]++; else mc[c] = 0;
          end else begin
            if (s < TH_OFF) mc[c]++; else mc[c] = 0;
          end
          if (mc[c] == DEB) begin
            mp[c] = ~mp[c];
            mc[c] = 0;
          end
        end
      end
    end
    e.sat = msat;
    sb.push_back(e);
    @(posedge CLK100MHZ);
    #1;
    e = sb.pop_front();
    chk("btn", 32'(bus.BTN), 32'(e.btn));
    chk("btn_event", 32'(bus.btn_event), 32'(e.ev));
    chk("sat", 32'(bus.sat), 32'(e.sat));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(0, 3000)), int'($urandom_range(0, 3000)));
  endtask

  initial begin
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    model_reset();
    #12;
    chk("rst_btn", 32'(bus.BTN), 0);
    chk("rst_ev", 32'(bus.btn_event), 0);
    chk("rst_sat", 32'(bus.sat), 0);
    @(negedge CLK100MHZ) rst = 1'b0;

    // basic press on ch0
    for (int i = 0; i < DEB; i++) step(1'b1, 1500, 0);
    idle(2);
    chk("press_btn", 32'(bus.BTN), 32'h1);

    // in-band samples never release; below TH_OFF does
    for (int i = 0; i < 5; i++) step(1'b1, 900, 0);
    idle(2);
    chk("hyst_hold", 32'(bus.BTN), 32'h1);
    for (int i = 0; i < DEB; i++) step(1'b1, 500, 0);
    idle(2);
    chk("release_btn", 32'(bus.BTN), 32'h0);

    // glitch breaks the press count
    step(1'b1, 1500, 0); step(1'b1, 1500, 0); step(1'b1, 900, 0);
    step(1'b1, 1500, 0); step(1'b1, 1500, 0);
    idle(2);
    chk("glitch_btn", 32'(bus.BTN), 32'h0);
    step(1'b1, 0, 0);

    // press with long invalid gaps (random data must be ignored)
    for (int i = 0; i < DEB; i++) begin
      step(1'b1, 1500, 0);
      idle(10);
    end
    chk("gap_btn", 32'(bus.BTN), 32'h1);

    // saturation masks then unmasks
    for (int i = 0; i < DEB; i++) step(1'b1, 1500, 1500);
    idle(2);
    chk("both_btn", 32'(bus.BTN), 32'h3);
    step(1'b1, 2500, 2500);
    step(1'b0, 0, 0);
    chk("sat_btn", 32'(bus.BTN), 32'h0);
    chk("sat_flag", 32'(bus.sat), 32'h1);
    step(1'b1, 1500, 1500);
    step(1'b0, 0, 0);
    chk("unsat_btn", 32'(bus.BTN), 32'h3);
    chk("unsat_flag", 32'(bus.sat), 32'h0);

    // simultaneous release of both channels
    for (int i = 0; i < DEB; i++) step(1'b1, 500, 500);
    idle(3);
    chk("rel_both", 32'(bus.BTN), 32'h0);

    // async reset mid-debounce with ch1 held
    for (int i = 0; i < DEB; i++) step(1'b1, 0, 1500);
    idle(2);
    chk("ch1_btn", 32'(bus.BTN), 32'h2);
    step(1'b1, 1500, 1500);
    step(1'b1, 1500, 1500);
    #1 rst = 1'b1;
    #1;
    chk("arst_btn", 32'(bus.BTN), 0);
    chk("arst_ev", 32'(bus.btn_event), 0);
    chk("arst_sat", 32'(bus.sat), 0);
    model_reset();
    @(negedge CLK100MHZ) rst = 1'b0;
    step(1'b1, 1500, 0);
    idle(3);
    chk("post_rst", 32'(bus.BTN), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
